// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO pop side and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
    parameter int G_WIDTH = 8,
    parameter int G_CNT_W = 16
);
    logic               i_flush;
    logic               o_fifo_rd;
    logic [G_WIDTH-1:0] i_fifo_data;
    logic               i_fifo_empty;
    logic               o_valid;
    logic [G_WIDTH-1:0] o_data;
    logic               i_ready;
    logic [G_CNT_W-1:0] o_count;
    logic               o_underflow;

    modport master (
        input  i_flush, i_fifo_data, i_fifo_empty, i_ready,
        output o_fifo_rd, o_valid, o_data, o_count, o_underflow
    );

    modport slave (
        output i_flush, i_fifo_data, i_fifo_empty, i_ready,
        input  o_fifo_rd, o_valid, o_data, o_count, o_underflow
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side consumer with 2-entry prefetch/skid buffer
module fifo_stream_reader #(
    parameter int G_WIDTH = 8,
    parameter int G_CNT_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fifo_stream_reader_if.master  bus
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [G_WIDTH-1:0] out_q, out_d;
    logic [G_WIDTH-1:0] skid_q, skid_d;
    logic               inflight_q;
    logic [G_CNT_W-1:0] count_q, count_d;
    logic               underflow_q, underflow_d;

    logic               pop;
    logic               ret;
    logic               rd;
    logic [1:0]         occ;
    logic [1:0]         committed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            inflight_q  <= rd;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        occ         = 2'd0;
        pop         = (state_q != S_EMPTY) && bus.i_ready;
        ret         = inflight_q && !bus.i_flush;

        case (state_q)
            S_ONE:   occ = 2'd1;
            S_TWO:   occ = 2'd2;
            default: occ = 2'd0;
        endcase

        // Words already owned by this block once this clk's pop leaves; never exceeds buffer depth.
        committed   = occ + {1'b0, inflight_q} - {1'b0, pop};
        rd          = i_rst_n && !bus.i_flush && !bus.i_fifo_empty && (committed < 2'd2);

        count_d     = count_q + {{(G_CNT_W-1){1'b0}}, pop};
        underflow_d = underflow_q | (rd & bus.i_fifo_empty);

        if (bus.i_flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (ret) begin
                        out_d   = bus.i_fifo_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (ret && !pop) begin
                        skid_d  = bus.i_fifo_data;
                        state_d = S_TWO;
                    end else if (ret && pop) begin
                        out_d   = bus.i_fifo_data;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        out_d   = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    assign bus.o_fifo_rd   = rd;
    assign bus.o_valid     = (state_q != S_EMPTY);
    assign bus.o_data      = out_q;
    assign bus.o_count     = count_q;
    assign bus.o_underflow = underflow_q;
endmodule
